// File: rtl/avr_uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the AVR data bus.
// Optional CTRL register and registered irq output when AVR_UART_TX_IRQ_EN is defined.
module avr_uart_tx_io #(
    parameter logic [15:0] BASE_ADDR  = 16'h0020,
    parameter int unsigned DIVISOR    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_addr,
    input  logic        data_wen,
    input  logic        data_ren,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
`ifdef AVR_UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [15:0] BaudLast = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [AW:0] wptr_q, rptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        ovf_q, ovf_d;
    logic [7:0]  rdata_d;

    logic sel_data, sel_status;
    logic full, empty, busy;
    logic push, pop, baud_end;
    logic [7:0] status;

    assign sel_data   = data_addr == BASE_ADDR;
    assign sel_status = data_addr == BASE_ADDR + 16'd1;

    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty    = wptr_q == rptr_q;
    assign busy     = state_q != StIdle;
    assign baud_end = cnt_q == BaudLast;
    assign status   = {4'b0000, ovf_q, busy, empty, full};

    // Fullness is judged before any same-cycle pop, so a pop never rescues a write.
    assign push = data_wen && sel_data && !full;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; pop is asserted when a frame is launched from the FIFO head
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) state_d = StData;
            end
            StData: begin
                if (baud_end && bit_idx_q == 3'd7) state_d = StStop;
            end
            StStop: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        tx = 1'b1;
        case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else if (pop) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= mem_q[rptr_q[AW-1:0]];
        end else if (state_q != StIdle) begin
            if (baud_end) begin
                cnt_q <= '0;
                if (state_q == StData) begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + 3'd1;
                end
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrOne;
            if (pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= data_write;
    end

    // Set and clear hit different addresses; set is applied last so it wins.
    always_comb begin
        ovf_d = ovf_q;
        if (data_wen && sel_status && data_write[3]) ovf_d = 1'b0;
        if (data_wen && sel_data && full)            ovf_d = 1'b1;
    end

`ifdef AVR_UART_TX_IRQ_EN
    logic sel_ctrl;
    logic irq_en_q;
    logic irq_q;

    assign sel_ctrl = data_addr == BASE_ADDR + 16'd2;
    assign irq      = irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (data_wen && sel_ctrl) irq_en_q <= data_write[0];
            irq_q <= irq_en_q && empty && !busy;
        end
    end
`endif

    always_comb begin
        rdata_d = 8'h00;
        if (data_ren) begin
            if (sel_status) begin
                rdata_d = status;
            end
`ifdef AVR_UART_TX_IRQ_EN
            else if (sel_ctrl) begin
                rdata_d = {7'b0000000, irq_en_q};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q     <= 1'b0;
            data_read <= 8'h00;
        end else begin
            ovf_q     <= ovf_d;
            data_read <= rdata_d;
        end
    end

endmodule

// File: tb/tb_avr_uart_tx_io.sv
// Randomised bench for avr_uart_tx_io checked against a frame-timeline reference model.
// Covers the irq output too when AVR_UART_TX_IRQ_EN is defined.
module tb_avr_uart_tx_io;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_addr;
    logic        data_wen;
    logic        data_ren;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic        tx;
`ifdef AVR_UART_TX_IRQ_EN
    logic        irq;
`endif

    avr_uart_tx_io #(
        .BASE_ADDR  (16'h0020),
        .DIVISOR    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_addr  (data_addr),
        .data_wen   (data_wen),
        .data_ren   (data_ren),
        .data_write (data_write),
        .data_read  (data_read),
`ifdef AVR_UART_TX_IRQ_EN
        .irq        (irq),
`endif
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued bytes plus the position inside the current 10-bit frame.
    logic [7:0] m_q[$];
    logic       m_active;
    int         m_pos;
    logic [9:0] m_frame;
    logic       m_ovf;
    logic       m_en;
    logic       m_irq;
    logic       m_tx;
    logic [7:0] m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_frame  = 10'h3ff;
        m_ovf    = 1'b0;
        m_en     = 1'b0;
        m_irq    = 1'b0;
        m_tx     = 1'b1;
        m_rd     = 8'h00;
    endtask

    task automatic model_edge(input logic wen, input logic ren, input logic [15:0] addr,
                              input logic [7:0] wd);
        logic       full_pre, empty_pre, act_pre, start;
        logic [7:0] st, b;
        full_pre  = m_q.size() == DEPTH;
        empty_pre = m_q.size() == 0;
        act_pre   = m_active;
        st        = {4'b0000, m_ovf, act_pre, empty_pre, full_pre};
        m_rd = 8'h00;
        if (ren && addr == 16'h0021) m_rd = st;
`ifdef AVR_UART_TX_IRQ_EN
        if (ren && addr == 16'h0022) m_rd = {7'b0, m_en};
        m_irq = m_en && empty_pre && !act_pre;
`endif
        start = 1'b0;
        if (act_pre) begin
            if (m_pos == 10 * DIV - 1) begin
                m_active = 1'b0;
                start    = !empty_pre;
            end else begin
                m_pos++;
            end
        end else begin
            start = !empty_pre;
        end
        if (start) begin
            b        = m_q.pop_front();
            m_frame  = {1'b1, b, 1'b0};
            m_pos    = 0;
            m_active = 1'b1;
        end
        if (wen && addr == 16'h0020) begin
            if (full_pre) m_ovf = 1'b1;
            else m_q.push_back(wd);
        end
        if (wen && addr == 16'h0021 && wd[3]) m_ovf = 1'b0;
`ifdef AVR_UART_TX_IRQ_EN
        if (wen && addr == 16'h0022) m_en = wd[0];
`endif
        m_tx = m_active ? m_frame[m_pos / DIV] : 1'b1;
    endtask

    task automatic cycle(input logic wen, input logic ren, input logic [15:0] addr,
                         input logic [7:0] wd);
        data_wen   = wen;
        data_ren   = ren;
        data_addr  = addr;
        data_write = wd;
        @(posedge clk);
        model_edge(wen, ren, addr, wd);
        #1;
        check_eq("tx", {31'b0, tx}, {31'b0, m_tx});
        check_eq("data_read", {24'b0, data_read}, {24'b0, m_rd});
`ifdef AVR_UART_TX_IRQ_EN
        check_eq("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
        data_wen = 1'b0;
        data_ren = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] wd);
        cycle(1'b1, 1'b0, addr, wd);
    endtask

    task automatic rd(input logic [15:0] addr);
        cycle(1'b0, 1'b1, addr, 8'h00);
    endtask

    initial begin
        logic [15:0] addrs [4];
        addrs[0] = 16'h0020;
        addrs[1] = 16'h0021;
        addrs[2] = 16'h0022;
        addrs[3] = 16'h0030;

        reset      = 1'b0;
        data_wen   = 1'b0;
        data_ren   = 1'b0;
        data_addr  = 16'h0000;
        data_write = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_data_read", {24'b0, data_read}, 32'd0);
        reset = 1'b1;

        // Read decode at reset
        rd(16'h0021);
        check_eq("status_at_reset", {24'b0, data_read}, 32'h02);
        rd(16'h0030);
        cycle(1'b0, 1'b0, 16'h0021, 8'h00);

        // Single byte with status polling
        wr(16'h0020, 8'h55);
        for (int i = 0; i < 45; i++) rd(16'h0021);

        // Back-to-back frames
        wr(16'h0020, 8'hA5);
        wr(16'h0020, 8'h3C);
        for (int i = 0; i < 85; i++) rd(16'h0021);

        // Overflow, sticky flag, then clear
        for (int i = 1; i <= 6; i++) wr(16'h0020, 8'(i));
        rd(16'h0021);
        check_eq("status_full_ovf", {24'b0, data_read}, 32'h0D);
        wr(16'h0021, 8'h08);
        rd(16'h0021);
        for (int i = 0; i < 200; i++) rd(16'h0021);

`ifdef AVR_UART_TX_IRQ_EN
        wr(16'h0022, 8'h01);
        rd(16'h0022);
        wr(16'h0020, 8'h81);
        idle(45);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        w, r;
            logic [15:0] a;
            w = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 1) == 1);
            a = addrs[$urandom_range(0, 3)];
            cycle(w, r, a, 8'($urandom));
        end
        idle(10 * DIV * (DEPTH + 2));

        // Reset during data bit 3 of a 0x55 frame (bit 3 is a 0)
        wr(16'h0020, 8'h55);
        idle(1 + DIV + 3 * DIV + 1);
        check_eq("tx_before_rst", {31'b0, tx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("tx_async_rst", {31'b0, tx}, 32'd1);
        check_eq("rd_async_rst", {24'b0, data_read}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        rd(16'h0021);
        check_eq("status_after_rst", {24'b0, data_read}, 32'h02);
        idle(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
